// File: rtl/dma_job_scheduler.sv
// Single-job sequencer for the read-DMA / DCT / write-DMA path, fed by a small descriptor FIFO.
// Optional WAIT watchdog is compiled in with `define DMA_SCHED_TIMEOUT_EN.
module dma_job_scheduler #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_BYTES     = 32,
    parameter int DESC_DEPTH     = 4,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  enable,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [ADDR_WIDTH-1:0] desc_src,
    input  logic [ADDR_WIDTH-1:0] desc_dst,
    input  logic [ADDR_WIDTH-1:0] desc_bytes,
    output logic                  rdma_start,
    output logic [ADDR_WIDTH-1:0] rdma_mem,
    output logic [ADDR_WIDTH-1:0] rdma_transfer_byte,
    input  logic                  rdma_done,
    output logic                  wdma_start,
    output logic [ADDR_WIDTH-1:0] wdma_mem,
    output logic [ADDR_WIDTH-1:0] wdma_transfer_byte,
    input  logic                  wdma_done,
    output logic                  busy,
    output logic                  job_done,
    output logic                  job_err,
    output logic [1:0]            err_code,
    output logic [CNT_WIDTH-1:0]  jobs_cnt,
    input  logic                  irq_en,
    input  logic                  irq_clr,
    output logic                  irq
);

    localparam int PTR_W = $clog2(DESC_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t r_state, w_next;

    logic [ADDR_WIDTH-1:0] r_q_src   [DESC_DEPTH];
    logic [ADDR_WIDTH-1:0] r_q_dst   [DESC_DEPTH];
    logic [ADDR_WIDTH-1:0] r_q_bytes [DESC_DEPTH];
    logic [PTR_W:0]        r_wptr, r_rptr;
    logic                  w_full, w_empty, w_push, w_pop;

    logic [ADDR_WIDTH-1:0] r_src, r_dst, r_bytes;
    logic [1:0]            r_err;
    logic                  r_rd_flag, r_wr_flag;
    logic                  w_both, w_bad_len, w_timeout;
    logic [CNT_WIDTH-1:0]  r_jobs_cnt;
    logic                  r_irq;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_push  = desc_valid & ~w_full;
    assign w_pop   = (r_state == S_IDLE) & enable & ~w_empty;

    // NOTE: queue storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge ap_clk) begin
        if (w_push) begin
            r_q_src[r_wptr[PTR_W-1:0]]   <= desc_src;
            r_q_dst[r_wptr[PTR_W-1:0]]   <= desc_dst;
            r_q_bytes[r_wptr[PTR_W-1:0]] <= desc_bytes;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_bytes <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr  <= r_rptr + 1'b1;
                r_src   <= r_q_src[r_rptr[PTR_W-1:0]];
                r_dst   <= r_q_dst[r_rptr[PTR_W-1:0]];
                r_bytes <= r_q_bytes[r_rptr[PTR_W-1:0]];
            end
        end
    end

    assign w_bad_len = (r_bytes == '0) ||
                       ((r_bytes % ADDR_WIDTH'(DATA_BYTES)) != '0);
    // This cycle's done inputs count, so a same-cycle pair retires immediately.
    assign w_both = (r_rd_flag | rdma_done) & (r_wr_flag | wdma_done);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rd_flag <= 1'b0;
            r_wr_flag <= 1'b0;
        end else if (r_state == S_ISSUE) begin
            r_rd_flag <= 1'b0;
            r_wr_flag <= 1'b0;
        end else if (r_state == S_WAIT) begin
            r_rd_flag <= r_rd_flag | rdma_done;
            r_wr_flag <= r_wr_flag | wdma_done;
        end
    end

`ifdef DMA_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)                 r_to_cnt <= '0;
        else if (r_state == S_ISSUE)   r_to_cnt <= '0;
        else if (r_state == S_WAIT)    r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign w_timeout = (r_state == S_WAIT) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog compiled out: WAIT holds until both engines report done.
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_pop) w_next = S_LOAD;
            S_LOAD:  w_next = w_bad_len ? S_DONE : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_both || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rdma_start = 1'b0;
        wdma_start = 1'b0;
        job_done   = 1'b0;
        job_err    = 1'b0;
        err_code   = 2'b00;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_ISSUE: begin
                rdma_start = 1'b1;
                wdma_start = 1'b1;
            end
            S_DONE: begin
                job_done = 1'b1;
                job_err  = |r_err;
                err_code = r_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_err      <= 2'b00;
            r_jobs_cnt <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_pop)                                       r_err <= 2'b00;
            else if (r_state == S_LOAD && w_bad_len)         r_err <= 2'b01;
            else if (r_state == S_WAIT && !w_both && w_timeout) r_err <= 2'b10;

            if (r_state == S_DONE && r_err == 2'b00) r_jobs_cnt <= r_jobs_cnt + 1'b1;

            // Set beats clear when both land in the same cycle.
            if (r_state == S_DONE && irq_en) r_irq <= 1'b1;
            else if (irq_clr)                r_irq <= 1'b0;
        end
    end

    assign desc_ready         = ~w_full;
    assign rdma_mem           = r_src;
    assign rdma_transfer_byte = r_bytes;
    assign wdma_mem           = r_dst;
    assign wdma_transfer_byte = r_bytes;
    assign jobs_cnt           = r_jobs_cnt;
    assign irq                = r_irq;

endmodule

// File: tb/tb_dma_job_scheduler.sv
// Directed self-checking bench for dma_job_scheduler; the watchdog scenario runs only
// when DMA_SCHED_TIMEOUT_EN is defined.
module tb_dma_job_scheduler;

    localparam int AW = 32;
    localparam int CW = 16;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          enable, desc_valid, desc_ready;
    logic [AW-1:0] desc_src, desc_dst, desc_bytes;
    logic          rdma_start, rdma_done, wdma_start, wdma_done;
    logic [AW-1:0] rdma_mem, rdma_transfer_byte, wdma_mem, wdma_transfer_byte;
    logic          busy, job_done, job_err;
    logic [1:0]    err_code;
    logic [CW-1:0] jobs_cnt;
    logic          irq_en, irq_clr, irq;

    int n_checks = 0;
    int n_errors = 0;
    int n_rstart = 0;
    int n_wstart = 0;
    int n_jdone  = 0;
    int exp_cnt  = 0;

    dma_job_scheduler #(
        .ADDR_WIDTH(AW), .DATA_BYTES(32), .DESC_DEPTH(4),
        .CNT_WIDTH(CW), .TIMEOUT_CYCLES(100)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(enable),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_src(desc_src), .desc_dst(desc_dst), .desc_bytes(desc_bytes),
        .rdma_start(rdma_start), .rdma_mem(rdma_mem),
        .rdma_transfer_byte(rdma_transfer_byte), .rdma_done(rdma_done),
        .wdma_start(wdma_start), .wdma_mem(wdma_mem),
        .wdma_transfer_byte(wdma_transfer_byte), .wdma_done(wdma_done),
        .busy(busy), .job_done(job_done), .job_err(job_err), .err_code(err_code),
        .jobs_cnt(jobs_cnt), .irq_en(irq_en), .irq_clr(irq_clr), .irq(irq)
    );

    always #5 ap_clk = ~ap_clk;

    always @(negedge ap_clk) begin
        if (rdma_start) n_rstart++;
        if (wdma_start) n_wstart++;
        if (job_done)   n_jdone++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] b);
        desc_valid = 1'b1;
        desc_src   = s;
        desc_dst   = d;
        desc_bytes = b;
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic r, input logic w);
        rdma_done = r;
        wdma_done = w;
        tick();
        rdma_done = 1'b0;
        wdma_done = 1'b0;
    endtask

    task automatic wait_start(input int max, output int n);
        n = 0;
        while (rdma_start !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        check("start_seen", rdma_start, 1'b1);
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (job_done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        check("job_done_seen", job_done, 1'b1);
    endtask

    initial begin
        int n;
        int rs0, ws0, jd0;
        logic [AW-1:0] src_e, dst_e, len_e;

        ap_rst_n   = 1'b0;
        enable     = 1'b0;
        desc_valid = 1'b0;
        desc_src   = '0;
        desc_dst   = '0;
        desc_bytes = '0;
        rdma_done  = 1'b0;
        wdma_done  = 1'b0;
        irq_en     = 1'b0;
        irq_clr    = 1'b0;
        tick();
        tick();

        check("rst_desc_ready", desc_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_start", {rdma_start, wdma_start}, 2'b00);
        check("rst_job_done", {job_done, job_err, err_code}, 4'h0);
        check("rst_mem", {rdma_mem, wdma_mem, rdma_transfer_byte}, 96'h0);
        check("rst_cnt_irq", {jobs_cnt, irq}, 17'h0);
        ap_rst_n = 1'b1;
        tick();

        // ---- single job, wdma done 40 cycles after rdma done ----
        enable = 1'b1;
        irq_en = 1'b1;
        push(32'h1000, 32'h8000, 32'h200);
        check("t1_busy_after_push", busy, 1'b0);
        tick();
        check("t1_load_no_start", rdma_start, 1'b0);
        check("t1_rdma_mem", rdma_mem, 32'h1000);
        check("t1_wdma_mem", wdma_mem, 32'h8000);
        check("t1_bytes", {rdma_transfer_byte, wdma_transfer_byte}, {32'h200, 32'h200});
        tick();
        check("t1_start_pulse", {rdma_start, wdma_start}, 2'b11);
        tick();
        check("t1_start_one_cycle", {rdma_start, wdma_start}, 2'b00);
        pulse_done(1'b1, 1'b0);
        for (int i = 0; i < 39; i++) tick();
        check("t1_wait_for_wdma", {job_done, busy}, 2'b01);
        pulse_done(1'b0, 1'b1);
        check("t1_job_done", {job_done, job_err, err_code}, 4'b1000);
        check("t1_irq_not_yet", irq, 1'b0);
        tick();
        check("t1_done_one_cycle", {job_done, busy}, 2'b00);
        check("t1_jobs_cnt", jobs_cnt, 16'd1);
        check("t1_irq", irq, 1'b1);
        check("t1_start_counts", {n_rstart[7:0], n_wstart[7:0]}, 16'h0101);
        exp_cnt = 1;
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("t1_irq_clr", irq, 1'b0);

        // ---- fill the queue with enable low, 5th push dropped ----
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("fill_ready", desc_ready, (i < 4) ? 1'b1 : 1'b0);
            push(32'h2000 + i * 32'h100, 32'h9000 + i * 32'h100, 32'h40 * (i + 1));
        end
        check("fill_full", desc_ready, 1'b0);
        tick();
        tick();
        check("fill_idle_disabled", busy, 1'b0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src_e = 32'h2000 + i * 32'h100;
            dst_e = 32'h9000 + i * 32'h100;
            len_e = 32'h40 * (i + 1);
            wait_start(20, n);
            if (i > 0) check("b2b_gap", n, 3);
            check("fill_src", rdma_mem, src_e);
            check("fill_dst", wdma_mem, dst_e);
            check("fill_len", wdma_transfer_byte, len_e);
            tick();
            pulse_done(1'b1, 1'b1);
            check("fill_same_cycle_done", {job_done, err_code}, 3'b100);
            exp_cnt++;
        end
        tick();
        check("fill_jobs_cnt", jobs_cnt, exp_cnt);
        check("fill_ready_again", desc_ready, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        check("fill_dropped_5th", {busy, n_rstart[7:0]}, {1'b0, 8'd5});
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;

        // ---- wdma done first, retire on rdma done; irq set beats clear ----
        push(32'h3000, 32'hA000, 32'h20);
        wait_start(20, n);
        tick();
        pulse_done(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        check("wfirst_hold", {job_done, busy}, 2'b01);
        irq_clr = 1'b1;
        pulse_done(1'b1, 1'b0);
        check("wfirst_retire", {job_done, job_err}, 2'b10);
        tick();
        irq_clr = 1'b0;
        check("irq_set_wins", irq, 1'b1);
        exp_cnt++;
        check("wfirst_cnt", jobs_cnt, exp_cnt);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;

        // ---- bad lengths, irq disabled ----
        irq_en = 1'b0;
        rs0 = n_rstart;
        ws0 = n_wstart;
        jd0 = n_jdone;
        push(32'h4000, 32'hB000, 32'h0);
        push(32'h4100, 32'hB100, 32'h30);
        wait_done(20, n);
        check("bad0_err", {job_err, err_code}, 3'b101);
        tick();
        wait_done(20, n);
        check("bad30_err", {job_err, err_code}, 3'b101);
        check("bad30_len_latched", rdma_transfer_byte, 32'h30);
        tick();
        tick();
        check("bad_no_starts", {n_rstart - rs0, n_wstart - ws0}, 64'h0);
        check("bad_two_done", n_jdone - jd0, 2);
        check("bad_cnt_same", jobs_cnt, exp_cnt);
        check("bad_irq_off", irq, 1'b0);
        irq_en = 1'b1;

`ifdef DMA_SCHED_TIMEOUT_EN
        // ---- watchdog: wdma never finishes ----
        push(32'h5000, 32'hC000, 32'h40);
        wait_start(20, n);
        tick();
        pulse_done(1'b1, 1'b0);
        wait_done(200, n);
        check("to_wait_cycles", n + 2, 101);
        check("to_err", {job_err, err_code}, 3'b110);
        tick();
        pulse_done(1'b0, 1'b1);
        check("to_late_done_ignored", {busy, job_done}, 2'b00);
        push(32'h5100, 32'hC100, 32'h40);
        wait_start(20, n);
        check("to_next_src", rdma_mem, 32'h5100);
        tick();
        pulse_done(1'b1, 1'b1);
        check("to_next_ok", {job_done, err_code}, 3'b100);
        exp_cnt++;
        tick();
        check("to_cnt", jobs_cnt, exp_cnt);
`endif

        // ---- reset during WAIT with two descriptors queued ----
        push(32'h6000, 32'hD000, 32'h20);
        push(32'h6100, 32'hD100, 32'h20);
        push(32'h6200, 32'hD200, 32'h20);
        wait_start(20, n);
        tick();
        check("rst_mid_in_wait", busy, 1'b1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("rstm_busy", busy, 1'b0);
        check("rstm_ready", desc_ready, 1'b1);
        check("rstm_outs", {rdma_mem, wdma_transfer_byte, jobs_cnt, irq, job_done}, 82'h0);
        rs0 = n_rstart;
        jd0 = n_jdone;
        tick();
        tick();
        ap_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("rstm_quiet", {busy, job_done, rdma_start}, 3'b000);
        check("rstm_no_activity", {n_rstart - rs0, n_jdone - jd0}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dma_job_scheduler.md
# dma_job_scheduler

Sequences the read-DMA / DCT / write-DMA datapath one job at a time from a small descriptor queue. The host pushes descriptors (source address, destination address, byte count). The scheduler pops one, issues matched one-cycle start pulses to the read and write DMA engines, and waits for both engines to report done. It then retires the job, updates status and raises an interrupt. It sits between the host register interface and the `ap_start`/`ap_done` control ports of the DMA engines.

## Interface
- ADDR_WIDTH, 32, address and byte-count width
- DATA_BYTES, 32, AXI beat size in bytes (256-bit bus); byte counts must be a multiple of this
- DESC_DEPTH, 4, descriptor queue depth (power of 2, ≥2)
- CNT_WIDTH, 16, width of the completed-job counter
- TIMEOUT_CYCLES, 65535, watchdog limit in WAIT (used only with DMA_SCHED_TIMEOUT_EN)

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- enable  in  1  allow popping new descriptors; a job in flight always completes
- desc_valid  in  1  descriptor push request
- desc_ready  out  1  queue not full
- desc_src  in  ADDR_WIDTH  read-DMA base address
- desc_dst  in  ADDR_WIDTH  write-DMA base address
- desc_bytes  in  ADDR_WIDTH  transfer byte count
- rdma_start  out  1  one-cycle start pulse to read DMA
- rdma_mem  out  ADDR_WIDTH  read base address, held stable from ISSUE until the next pop
- rdma_transfer_byte  out  ADDR_WIDTH  read byte count, held like rdma_mem
- rdma_done  in  1  read DMA done pulse
- wdma_start  out  1  one-cycle start pulse to write DMA
- wdma_mem  out  ADDR_WIDTH  write base address, held like rdma_mem
- wdma_transfer_byte  out  ADDR_WIDTH  write byte count, held like rdma_mem
- wdma_done  in  1  write DMA done pulse
- busy  out  1  state ≠ IDLE
- job_done  out  1  one-cycle retire pulse
- job_err  out  1  qualifies job_done: job failed
- err_code  out  2  00 none, 01 bad length, 10 timeout; valid with job_done
- jobs_cnt  out  CNT_WIDTH  successfully completed jobs, wraps
- irq_en  in  1  interrupt enable
- irq_clr  in  1  clear irq
- irq  out  1  level interrupt

## Operation
- Queue: registered FIFO. `desc_ready = ~full`. A push is accepted when `desc_valid & desc_ready`.
  - A push and a pop in the same cycle are both honoured.
  - A push while full is dropped; the host must respect `desc_ready`.
- States: IDLE, LOAD, ISSUE, WAIT, DONE.
- IDLE:
  - If `enable & ~empty`: pop, latch the descriptor into the output registers, go to LOAD.
- LOAD:
  - If `desc_bytes == 0` or `desc_bytes % DATA_BYTES != 0`: go to DONE with err_code 01. No start pulses are issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - `rdma_start` and `wdma_start` are high for exactly this cycle.
  - Clear the done flags. Go to WAIT.
- WAIT:
  - `rdma_done` sets sticky flag r_done; `wdma_done` sets sticky flag w_done. The two may arrive in either order or in the same cycle.
  - When both flags are set (including via this cycle's inputs), go to DONE.
  - Done pulses seen outside WAIT are ignored.
- DONE:
  - `job_done` is high for one cycle, with `job_err` and `err_code`.
  - `jobs_cnt` increments only if err_code is 00.
  - If `irq_en`, set irq. Go to IDLE.
- irq: set by DONE when `irq_en`; cleared by `irq_clr`. If set and clear occur in the same cycle, set wins.
- Start pulses are single-cycle, with at least 3 low cycles between jobs, so the rising-edge start detectors in the engines see every job.

## Timing
- Reset values: all outputs are 0, except `desc_ready`, which is 1. State is IDLE, the queue is empty and the flags are cleared.
- Reset mid-job: abandon immediately. Queue contents are lost and no `job_done` is issued.
- Push accepted at edge t into an empty queue while IDLE and enabled:
  - pop at edge t+1;
  - LOAD during cycle t+1→t+2;
  - start pulses during cycle t+2→t+3.
- Last done pulse sampled at edge d: `job_done` is high in cycle d→d+1, `irq` is high from edge d+1, and IDLE is reached at edge d+1.
- Back-to-back jobs: next start pulse at the earliest 3 cycles after `job_done`.
- `enable` deasserted: sampled only in IDLE.

## Configuration
- DMA_SCHED_TIMEOUT_EN defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears in ISSUE and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with both flags not yet set, go to DONE with err_code 10.
  - The engines are not reset; the late done pulses that follow are ignored.
- Undefined: no counter, and WAIT waits indefinitely. err_code 10 never occurs.

## Test plan
- Single job: src 0x1000, dst 0x8000, bytes 0x200. Wdma done arrives 40 cycles after rdma done → one start pulse each, 2 cycles after the push edge; `job_done=1`, `job_err=0`, `jobs_cnt=1`; `irq=1` with `irq_en`; `irq_clr` gives `irq=0`.
- Fill the queue: push 5 descriptors back-to-back with DESC_DEPTH=4 and `enable=0` → `desc_ready=0` after 4 accepted; raise `enable` → 4 jobs run in push order, `jobs_cnt=4`.
- Bad length: bytes 0x0, then bytes 0x30 → no start pulses; 2 `job_done` pulses with err_code 01; `jobs_cnt` unchanged.
- Simultaneous done: rdma_done and wdma_done in the same cycle → `job_done` exactly 1 cycle later. Also: wdma_done arriving before rdma_done → retire on rdma_done.
- Timeout (DMA_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=100): never send wdma_done → `job_done` with err_code 10 after 100 WAIT cycles; the next job starts normally.
- Reset: deassert `ap_rst_n` during WAIT with 2 descriptors queued → all outputs 0 immediately, `desc_ready=1`; after release, no activity until a new push.
